// File: rtl/crono_bcd_timer.sv
// -----------------------------------------------------------------------------
// crono_bcd_timer
//
// Loadable HH:MM:SS countdown timer for the "crono" row of the VGA display.
// A free-running prescaler derives a one-second tick from the board clock.
// On every tick the six BCD digits count down by one second with borrow.
// The timer stops at 00:00:00 and raises a terminal "done" flag for the
// display and buzzer logic.
//
// Ports:
//   clk_i        system clock (100 MHz on the board)
//   reset_i      asynchronous, active-high reset
//   start_i      one-cycle pulse: start or resume the countdown
//   stop_i       one-cycle pulse: pause the countdown
//   clear_i      one-cycle pulse: zero all digits and return to idle
//   load_i       one-cycle pulse: capture load_bcd_i
//   load_bcd_i   {DH,UH,DM,UM,DS,US}, 4-bit BCD each, DH in bits 23:20
//   dig_*_o      current time in BCD, registered
//   running_o    high while counting
//   done_o       high once the countdown has reached zero
//   load_err_o   one-cycle pulse when a load is rejected
// -----------------------------------------------------------------------------
module crono_bcd_timer #(
    parameter int TICK_DIV = 100000000,
    parameter int HOUR_MAX = 23
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [23:0] load_bcd_i,
    output logic [3:0]  dig_dh_o,
    output logic [3:0]  dig_uh_o,
    output logic [3:0]  dig_dm_o,
    output logic [3:0]  dig_um_o,
    output logic [3:0]  dig_ds_o,
    output logic [3:0]  dig_us_o,
    output logic        running_o,
    output logic        done_o,
    output logic        load_err_o
);

    localparam int                 PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [6:0]         HOUR_LIMIT = 7'(HOUR_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [PRESC_W-1:0] r_presc;
    logic [3:0]         r_dh;
    logic [3:0]         r_uh;
    logic [3:0]         r_dm;
    logic [3:0]         r_um;
    logic [3:0]         r_ds;
    logic [3:0]         r_us;
    logic               r_running;
    logic               r_done;
    logic               r_load_err;

    // Split the load word into its six BCD fields.
    logic [3:0] w_ld_dh;
    logic [3:0] w_ld_uh;
    logic [3:0] w_ld_dm;
    logic [3:0] w_ld_um;
    logic [3:0] w_ld_ds;
    logic [3:0] w_ld_us;
    logic [6:0] w_ld_hour;
    logic       w_load_legal;

    assign w_ld_dh = load_bcd_i[23:20];
    assign w_ld_uh = load_bcd_i[19:16];
    assign w_ld_dm = load_bcd_i[15:12];
    assign w_ld_um = load_bcd_i[11:8];
    assign w_ld_ds = load_bcd_i[7:4];
    assign w_ld_us = load_bcd_i[3:0];

    // The hour limit applies to the decoded two-digit value, so DH=2/UH=4
    // is rejected even though both digits are valid BCD on their own.
    assign w_ld_hour = ({3'b000, w_ld_dh} * 7'd10) + {3'b000, w_ld_uh};

    // A load is legal only if every digit is valid BCD, the tens of minutes
    // and seconds stay within 0..5, and the decoded hour is within range.
    assign w_load_legal = (w_ld_dh <= 4'd9) && (w_ld_uh <= 4'd9) &&
                          (w_ld_dm <= 4'd5) && (w_ld_um <= 4'd9) &&
                          (w_ld_ds <= 4'd5) && (w_ld_us <= 4'd9) &&
                          (w_ld_hour <= HOUR_LIMIT);

    // Control pulses are resolved by priority: clear > load > stop > start.
    // A higher pulse masks every lower one in the same cycle, even when the
    // higher pulse itself has no effect in the current state.
    logic w_do_load;
    logic w_do_stop;
    logic w_do_start;

    assign w_do_load  = load_i  & ~clear_i;
    assign w_do_stop  = stop_i  & ~clear_i & ~load_i;
    assign w_do_start = start_i & ~clear_i & ~load_i & ~stop_i;

    // The one-second tick exists only while running, in the last prescaler
    // count of each period.
    logic w_tick;
    assign w_tick = (r_state == S_RUN) && (r_presc == PRESC_LAST);

    logic w_time_zero;
    assign w_time_zero = (r_dh == 4'd0) && (r_uh == 4'd0) && (r_dm == 4'd0) &&
                         (r_um == 4'd0) && (r_ds == 4'd0) && (r_us == 4'd0);

    // Next time value for a one-second decrement. Each digit borrows from
    // the next more significant digit only when it wraps, and the wrap value
    // is 9 for unit digits and 5 for tens of minutes/seconds. Hours behave
    // as a plain two-digit BCD value. The tens-of-hours digit saturates at
    // zero so the outputs stay legal BCD even if a decrement were ever
    // requested at 00:00:00.
    logic [3:0] w_nx_dh;
    logic [3:0] w_nx_uh;
    logic [3:0] w_nx_dm;
    logic [3:0] w_nx_um;
    logic [3:0] w_nx_ds;
    logic [3:0] w_nx_us;
    logic       w_bor_us;
    logic       w_bor_ds;
    logic       w_bor_um;
    logic       w_bor_dm;
    logic       w_bor_uh;
    logic       w_next_zero;

    assign w_bor_us = (r_us == 4'd0);
    assign w_nx_us  = w_bor_us ? 4'd9 : (r_us - 4'd1);

    assign w_bor_ds = w_bor_us && (r_ds == 4'd0);
    assign w_nx_ds  = !w_bor_us ? r_ds : ((r_ds == 4'd0) ? 4'd5 : (r_ds - 4'd1));

    assign w_bor_um = w_bor_ds && (r_um == 4'd0);
    assign w_nx_um  = !w_bor_ds ? r_um : ((r_um == 4'd0) ? 4'd9 : (r_um - 4'd1));

    assign w_bor_dm = w_bor_um && (r_dm == 4'd0);
    assign w_nx_dm  = !w_bor_um ? r_dm : ((r_dm == 4'd0) ? 4'd5 : (r_dm - 4'd1));

    assign w_bor_uh = w_bor_dm && (r_uh == 4'd0);
    assign w_nx_uh  = !w_bor_dm ? r_uh : ((r_uh == 4'd0) ? 4'd9 : (r_uh - 4'd1));

    assign w_nx_dh  = !w_bor_uh ? r_dh : ((r_dh == 4'd0) ? 4'd0 : (r_dh - 4'd1));

    assign w_next_zero = (w_nx_dh == 4'd0) && (w_nx_uh == 4'd0) && (w_nx_dm == 4'd0) &&
                         (w_nx_um == 4'd0) && (w_nx_ds == 4'd0) && (w_nx_us == 4'd0);

    // Main controller: state, prescaler, digits and status flags are all
    // updated together so every output changes on the same clock edge as
    // the state it reflects. Clear and a legal load act the same way from
    // any non-running state; the per-state case handles start, stop and
    // the countdown itself. The tick that reaches 00:00:00 enters DONE in
    // the same update, so no state ever shows zero time while running.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_dh       <= 4'd0;
            r_uh       <= 4'd0;
            r_dm       <= 4'd0;
            r_um       <= 4'd0;
            r_ds       <= 4'd0;
            r_us       <= 4'd0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= 1'b0;
            if (clear_i) begin
                r_state   <= S_IDLE;
                r_presc   <= '0;
                r_dh      <= 4'd0;
                r_uh      <= 4'd0;
                r_dm      <= 4'd0;
                r_um      <= 4'd0;
                r_ds      <= 4'd0;
                r_us      <= 4'd0;
                r_running <= 1'b0;
                r_done    <= 1'b0;
            end else if (w_do_load && (r_state != S_RUN)) begin
                if (w_load_legal) begin
                    r_state   <= S_IDLE;
                    r_presc   <= '0;
                    r_dh      <= w_ld_dh;
                    r_uh      <= w_ld_uh;
                    r_dm      <= w_ld_dm;
                    r_um      <= w_ld_um;
                    r_ds      <= w_ld_ds;
                    r_us      <= w_ld_us;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_do_start && !w_time_zero) begin
                            r_state   <= S_RUN;
                            r_presc   <= '0;
                            r_running <= 1'b1;
                        end
                    end

                    S_RUN: begin
                        if (w_do_stop) begin
                            r_state   <= S_PAUSE;
                            r_running <= 1'b0;
                        end else if (w_tick) begin
                            r_presc <= '0;
                            if (!w_time_zero) begin
                                r_dh <= w_nx_dh;
                                r_uh <= w_nx_uh;
                                r_dm <= w_nx_dm;
                                r_um <= w_nx_um;
                                r_ds <= w_nx_ds;
                                r_us <= w_nx_us;
                            end
                            if (w_next_zero || w_time_zero) begin
                                r_state   <= S_DONE;
                                r_running <= 1'b0;
                                r_done    <= 1'b1;
                            end
                        end else begin
                            r_presc <= r_presc + PRESC_W'(1);
                        end
                    end

                    S_PAUSE: begin
                        if (w_do_start && !w_time_zero) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end

                    S_DONE: begin
                        r_done <= 1'b1;
                    end

                    default: begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                        r_done    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dig_dh_o   = r_dh;
    assign dig_uh_o   = r_uh;
    assign dig_dm_o   = r_dm;
    assign dig_um_o   = r_um;
    assign dig_ds_o   = r_ds;
    assign dig_us_o   = r_us;
    assign running_o  = r_running;
    assign done_o     = r_done;
    assign load_err_o = r_load_err;

endmodule

// File: tb/tb_crono_bcd_timer.sv
// -----------------------------------------------------------------------------
// tb_crono_bcd_timer
//
// Directed testbench for crono_bcd_timer with a 4-cycle second. Inputs are
// driven 1 ns after the rising edge and outputs are sampled at the same
// point, so each applyStimulus call covers exactly one clock edge.
// -----------------------------------------------------------------------------
module tb_crono_bcd_timer;

    logic        clk_i;
    logic        reset_i;
    logic        start_i;
    logic        stop_i;
    logic        clear_i;
    logic        load_i;
    logic [23:0] load_bcd_i;
    logic [3:0]  dig_dh_o;
    logic [3:0]  dig_uh_o;
    logic [3:0]  dig_dm_o;
    logic [3:0]  dig_um_o;
    logic [3:0]  dig_ds_o;
    logic [3:0]  dig_us_o;
    logic        running_o;
    logic        done_o;
    logic        load_err_o;

    logic [23:0] timeNow;
    int          checkCount;
    int          errorCount;

    crono_bcd_timer #(
        .TICK_DIV(4),
        .HOUR_MAX(23)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .clear_i    (clear_i),
        .load_i     (load_i),
        .load_bcd_i (load_bcd_i),
        .dig_dh_o   (dig_dh_o),
        .dig_uh_o   (dig_uh_o),
        .dig_dm_o   (dig_dm_o),
        .dig_um_o   (dig_um_o),
        .dig_ds_o   (dig_ds_o),
        .dig_us_o   (dig_us_o),
        .running_o  (running_o),
        .done_o     (done_o),
        .load_err_o (load_err_o)
    );

    assign timeNow = {dig_dh_o, dig_uh_o, dig_dm_o, dig_um_o, dig_ds_o, dig_us_o};

    // 100 MHz-style clock, 10 ns period.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Safety net so a stuck simulation still ends with a report.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Drive one cycle of control pulses, let one edge consume them, then
    // return all pulses to zero.
    task automatic applyStimulus(input logic start, input logic stop, input logic clear,
                                 input logic load, input logic [23:0] bcd);
        start_i    = start;
        stop_i     = stop;
        clear_i    = clear;
        load_i     = load;
        load_bcd_i = bcd;
        @(posedge clk_i);
        #1;
        start_i    = 1'b0;
        stop_i     = 1'b0;
        clear_i    = 1'b0;
        load_i     = 1'b0;
        load_bcd_i = 24'h000000;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset_i    = 1'b1;
        start_i    = 1'b0;
        stop_i     = 1'b0;
        clear_i    = 1'b0;
        load_i     = 1'b0;
        load_bcd_i = 24'h000000;

        // Reset state.
        waitCycles(2);
        checkOutput("reset_time", 32'(timeNow), 32'h000000);
        checkOutput("reset_running", 32'(running_o), 32'd0);
        checkOutput("reset_done", 32'(done_o), 32'd0);
        checkOutput("reset_load_err", 32'(load_err_o), 32'd0);
        reset_i = 1'b0;
        waitCycles(1);

        // Reset asserted mid-run acts without a clock edge.
        $display("[TB] reset mid-run");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h000005);
        checkOutput("rst_load_time", 32'(timeNow), 32'h000005);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
        checkOutput("rst_running", 32'(running_o), 32'd1);
        waitCycles(1);
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("rst_async_time", 32'(timeNow), 32'h000000);
        checkOutput("rst_async_running", 32'(running_o), 32'd0);
        checkOutput("rst_async_done", 32'(done_o), 32'd0);
        waitCycles(1);
        reset_i = 1'b0;
        waitCycles(1);

        // Borrow chain across every digit.
        $display("[TB] borrow chain");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h010000);
        checkOutput("bor_load", 32'(timeNow), 32'h010000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
        checkOutput("bor_running", 32'(running_o), 32'd1);
        waitCycles(3);
        checkOutput("bor_before_tick", 32'(timeNow), 32'h010000);
        waitCycles(1);
        checkOutput("bor_tick1", 32'(timeNow), 32'h005959);
        waitCycles(4);
        checkOutput("bor_tick2", 32'(timeNow), 32'h005958);
        checkOutput("bor_still_running", 32'(running_o), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 24'h000000);
        checkOutput("bor_clear_time", 32'(timeNow), 32'h000000);
        checkOutput("bor_clear_running", 32'(running_o), 32'd0);

        // Terminal count, start ignored in DONE, clear leaves DONE.
        $display("[TB] terminal");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h000002);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
        waitCycles(4);
        checkOutput("term_tick1", 32'(timeNow), 32'h000001);
        checkOutput("term_tick1_done", 32'(done_o), 32'd0);
        waitCycles(4);
        checkOutput("term_zero", 32'(timeNow), 32'h000000);
        checkOutput("term_done", 32'(done_o), 32'd1);
        checkOutput("term_running", 32'(running_o), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
        checkOutput("term_start_done", 32'(done_o), 32'd1);
        checkOutput("term_start_running", 32'(running_o), 32'd0);
        waitCycles(4);
        checkOutput("term_hold_time", 32'(timeNow), 32'h000000);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 24'h000000);
        checkOutput("term_clear_done", 32'(done_o), 32'd0);

        // Illegal loads are rejected with a one-cycle error pulse.
        $display("[TB] illegal loads");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h123456);
        checkOutput("ill_base", 32'(timeNow), 32'h123456);
        checkOutput("ill_base_err", 32'(load_err_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h240000);
        checkOutput("ill_24h_err", 32'(load_err_o), 32'd1);
        checkOutput("ill_24h_time", 32'(timeNow), 32'h123456);
        waitCycles(1);
        checkOutput("ill_err_pulse_end", 32'(load_err_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h006000);
        checkOutput("ill_60m_err", 32'(load_err_o), 32'd1);
        checkOutput("ill_60m_time", 32'(timeNow), 32'h123456);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h00000A);
        checkOutput("ill_0a_err", 32'(load_err_o), 32'd1);
        checkOutput("ill_0a_time", 32'(timeNow), 32'h123456);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h235959);
        checkOutput("ill_max_err", 32'(load_err_o), 32'd0);
        checkOutput("ill_max_time", 32'(timeNow), 32'h235959);

        // Pause two cycles into a period, resume keeps the prescaler.
        $display("[TB] pause and resume");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h000010);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
        waitCycles(2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
        checkOutput("pau_running", 32'(running_o), 32'd0);
        waitCycles(20);
        checkOutput("pau_frozen", 32'(timeNow), 32'h000010);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
        checkOutput("pau_resume_running", 32'(running_o), 32'd1);
        waitCycles(1);
        checkOutput("pau_resume_pre", 32'(timeNow), 32'h000010);
        waitCycles(1);
        checkOutput("pau_resume_tick", 32'(timeNow), 32'h000009);

        // Priority: clear beats stop while running.
        $display("[TB] priority");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 24'h000000);
        checkOutput("pri_clear_time", 32'(timeNow), 32'h000000);
        checkOutput("pri_clear_running", 32'(running_o), 32'd0);

        // Priority: load beats start while paused.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h000030);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
        checkOutput("pri_paused", 32'(running_o), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 24'h000100);
        checkOutput("pri_load_time", 32'(timeNow), 32'h000100);
        checkOutput("pri_load_running", 32'(running_o), 32'd0);
        waitCycles(8);
        checkOutput("pri_load_idle_hold", 32'(timeNow), 32'h000100);

        // Stop in the tick cycle suppresses the decrement.
        $display("[TB] stop on tick");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 24'h000005);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
        waitCycles(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
        checkOutput("sot_no_dec", 32'(timeNow), 32'h000005);
        checkOutput("sot_running", 32'(running_o), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);
        checkOutput("sot_resume_time", 32'(timeNow), 32'h000005);
        waitCycles(1);
        checkOutput("sot_resume_tick", 32'(timeNow), 32'h000004);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
